// File: rtl/rls_sequencer_if.sv
// Control bundle between the RLS sequencer and the shared datapath.
// newIt_i is a level request with no ready: it is honoured only while the sequencer is idle.
interface rls_sequencer_if;
  logic        newIt_i;
  logic        load_o;
  logic        clears_o;
  logic        clear_o;
  logic        sha_o;
  logic        shk_o;
  logic        shx0_o;
  logic        shx_o;
  logic        s1_o;
  logic        s2_o;
  logic        enmult_o;
  logic        enadder_o;
  logic        ens_o;
  logic        loadx_o;
  logic        write_o;
  logic        busy_o;
  logic        final_o;
  logic [31:0] iterations_o;
  logic [3:0]  dbg_state_o;

  modport master (
    input  newIt_i,
    output load_o, clears_o, clear_o, sha_o, shk_o, shx0_o, shx_o, s1_o, s2_o,
           enmult_o, enadder_o, ens_o, loadx_o, write_o, busy_o, final_o,
           iterations_o, dbg_state_o
  );

  modport slave (
    output newIt_i,
    input  load_o, clears_o, clear_o, sha_o, shk_o, shx0_o, shx_o, s1_o, s2_o,
           enmult_o, enadder_o, ens_o, loadx_o, write_o, busy_o, final_o,
           iterations_o, dbg_state_o
  );
endinterface

// File: rtl/rls_sequencer.sv
// Sequences one RLS iteration (dot product, error, x update, commit) over the shared
// datapath; all enables and mux selects are Moore outputs of the state plus two delay lines.
module rls_sequencer #(
  parameter int N     = 2,
  parameter int MAXIT = 16,
  parameter int LMUL  = 1
) (
  input  logic            clk,
  input  logic            reset,
  rls_sequencer_if.master bus
);

  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(LMUL + 2);
  localparam int UW = LMUL + 1;
  localparam logic [EW-1:0] E_LAST = EW'(N - 1);
  // Drains run LMUL+2 cycles so the last accumulate/update has also been registered.
  localparam logic [DW-1:0] D_LAST = DW'(LMUL + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    DOT    = 4'd2,
    DRAIN1 = 4'd3,
    ERR    = 4'd4,
    UPD    = 4'd5,
    DRAIN2 = 4'd6,
    COMMIT = 4'd7,
    DONE   = 4'd8
  } state_e;

  state_e         state_q, state_d;
  logic [EW-1:0]  e_q, e_d;
  logic [DW-1:0]  d_q, d_d;
  logic [31:0]    iter_q, iter_d;
  logic [LMUL-1:0] dot_dl_q, dot_dl_d;
  logic [UW-1:0]  upd_dl_q, upd_dl_d;

  logic load, clears, clear, sha, shk, shx0, s1, s2, enmult, loadx, write, busy;
  logic dot_en, upd_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      e_q      <= '0;
      d_q      <= '0;
      iter_q   <= '0;
      dot_dl_q <= '0;
      upd_dl_q <= '0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      d_q      <= d_d;
      iter_q   <= iter_d;
      dot_dl_q <= dot_dl_d;
      upd_dl_q <= upd_dl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    e_d     = '0;
    d_d     = '0;
    iter_d  = iter_q;
    load    = 1'b0;
    clears  = 1'b0;
    clear   = 1'b0;
    sha     = 1'b0;
    shk     = 1'b0;
    shx0    = 1'b0;
    s1      = 1'b0;
    s2      = 1'b0;
    enmult  = 1'b0;
    loadx   = 1'b0;
    write   = 1'b0;
    busy    = 1'b0;
    dot_en  = 1'b0;
    upd_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.newIt_i) state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        load    = 1'b1;
        clears  = 1'b1;
        clear   = (iter_q == 32'd0);
        state_d = DOT;
      end
      DOT: begin
        busy   = 1'b1;
        sha    = 1'b1;
        shx0   = 1'b1;
        enmult = 1'b1;
        dot_en = 1'b1;
        if (e_q == E_LAST) state_d = DRAIN1;
        else               e_d = e_q + EW'(1);
      end
      DRAIN1: begin
        busy = 1'b1;
        if (d_q == D_LAST) state_d = ERR;
        else               d_d = d_q + DW'(1);
      end
      ERR: begin
        busy    = 1'b1;
        s1      = 1'b1;
        state_d = UPD;
      end
      UPD: begin
        busy   = 1'b1;
        shk    = 1'b1;
        shx0   = 1'b1;
        enmult = 1'b1;
        s1     = 1'b1;
        s2     = 1'b1;
        upd_en = 1'b1;
        if (e_q == E_LAST) state_d = DRAIN2;
        else               e_d = e_q + EW'(1);
      end
      DRAIN2: begin
        busy = 1'b1;
        if (d_q == D_LAST) state_d = COMMIT;
        else               d_d = d_q + DW'(1);
      end
      COMMIT: begin
        busy   = 1'b1;
        loadx  = 1'b1;
        write  = 1'b1;
        iter_d = (iter_q < 32'(MAXIT)) ? iter_q + 32'd1 : iter_q;
        state_d = (iter_d == 32'(MAXIT)) ? DONE : IDLE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator enables trail the dot-phase multiplier enable by LMUL; the x shifter
  // trails the update-phase enable by one more cycle for the registered x0+r*k adder.
  always_comb begin
    dot_dl_d = (dot_dl_q << 1) | LMUL'(dot_en);
    upd_dl_d = (upd_dl_q << 1) | UW'(upd_en);
  end

  assign bus.load_o       = load;
  assign bus.clears_o     = clears;
  assign bus.clear_o      = clear;
  assign bus.sha_o        = sha;
  assign bus.shk_o        = shk;
  assign bus.shx0_o       = shx0;
  assign bus.shx_o        = upd_dl_q[UW-1];
  assign bus.s1_o         = s1;
  assign bus.s2_o         = s2;
  assign bus.enmult_o     = enmult;
  assign bus.enadder_o    = dot_dl_q[LMUL-1];
  assign bus.ens_o        = dot_dl_q[LMUL-1];
  assign bus.loadx_o      = loadx;
  assign bus.write_o      = write;
  assign bus.busy_o       = busy;
  assign bus.final_o      = (state_q == DONE);
  assign bus.iterations_o = iter_q;
  assign bus.dbg_state_o  = state_q;

endmodule

// File: tb/tb_rls_sequencer.sv
// Bench for rls_sequencer: hand-written cycle tables for one iteration plus random
// newIt/reset traffic checked against a cycle-offset model of an iteration.
module tb_rls_sequencer;
  localparam int N     = 2;
  localparam int L     = 1;
  localparam int MAXIT = 3;
  localparam int T     = 2 * N + 2 * L + 7;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rls_sequencer_if bus ();

  rls_sequencer #(.N(N), .MAXIT(MAXIT), .LMUL(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          m_p    = 0;
  int          m_it   = 0;
  bit          m_fin  = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        new_it;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[14];

  // {load,clears,clear,sha,shk,shx0,shx,s1,s2,enmult,enadder,ens,loadx,write,busy,final}
  function automatic logic [15:0] obs();
    return {bus.load_o, bus.clears_o, bus.clear_o, bus.sha_o, bus.shk_o, bus.shx0_o,
            bus.shx_o, bus.s1_o, bus.s2_o, bus.enmult_o, bus.enadder_o, bus.ens_o,
            bus.loadx_o, bus.write_o, bus.busy_o, bus.final_o};
  endfunction

  // p is the 1-based cycle within an iteration (0 = not running).
  function automatic logic [15:0] model_vec(int p, int it, bit fin);
    logic [15:0] v;
    bit dot, upd;
    v   = '0;
    dot = (p >= 2) && (p <= N + 1);
    upd = (p >= N + L + 5) && (p <= 2 * N + L + 4);
    v[15] = (p == 1);
    v[14] = (p == 1);
    v[13] = (p == 1) && (it == 0);
    v[12] = dot;
    v[11] = upd;
    v[10] = dot || upd;
    v[9]  = (p >= N + 2 * L + 6) && (p <= 2 * N + 2 * L + 5);
    v[8]  = (p >= N + L + 4) && (p <= 2 * N + L + 4);
    v[7]  = upd;
    v[6]  = dot || upd;
    v[5]  = (p >= 2 + L) && (p <= N + 1 + L);
    v[4]  = v[5];
    v[3]  = (p == T);
    v[2]  = (p == T);
    v[1]  = (p != 0);
    v[0]  = fin;
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p   = 0;
    m_it  = 0;
    m_fin = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_advance(input bit nv);
    if (m_p != 0) begin
      if (m_p == T) begin
        m_p = 0;
        if (m_it < MAXIT) m_it++;
        if (m_it == MAXIT) m_fin = 1'b1;
      end else begin
        m_p++;
      end
    end else if (nv && !m_fin) begin
      m_p = 1;
    end
  endtask

  task automatic cycle(input bit nv);
    bus.newIt_i = nv;
    @(posedge clk);
    model_advance(nv);
    #1;
    if (m_p == T) exp_q.push_back(32'(m_it));
    check_vec("model_outputs", obs(), model_vec(m_p, m_it, m_fin));
    check_int("iterations", bus.iterations_o, 32'(m_it));
    if (bus.write_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write_unexpected at %0t: got write=1 expected none", $time);
      end else begin
        check_int("write_index", bus.iterations_o, exp_q.pop_front());
      end
    end
  endtask

  // Asserts reset between clock edges and checks the outputs drop before any edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_vec("reset_outputs", obs(), 16'h0000);
    check_int("reset_iterations", bus.iterations_o, 32'd0);
    check_int("reset_state", 32'(bus.dbg_state_o), 32'd0);
    @(posedge clk);
    #1;
    check_vec("reset_hold", obs(), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    bus.newIt_i = 1'b0;
  endtask

  task automatic run_table(input bit first, input bit hold_upd);
    logic [15:0] e;
    bit nv;
    for (int i = 0; i < 14; i++) begin
      nv = tbl[i].new_it | (hold_upd && (i >= 8));
      cycle(nv);
      e = tbl[i].exp;
      if (!first) e[13] = 1'b0;
      check_vec($sformatf("table_row_%0d", i), obs(), e);
    end
  endtask

  initial begin
    int writes, loads, rc;
    tbl[0]  = '{1'b1, 16'b1110_0000_0000_0010};
    tbl[1]  = '{1'b0, 16'b0001_0100_0100_0010};
    tbl[2]  = '{1'b0, 16'b0001_0100_0111_0010};
    tbl[3]  = '{1'b0, 16'b0000_0000_0011_0010};
    tbl[4]  = '{1'b0, 16'b0000_0000_0000_0010};
    tbl[5]  = '{1'b0, 16'b0000_0000_0000_0010};
    tbl[6]  = '{1'b0, 16'b0000_0001_0000_0010};
    tbl[7]  = '{1'b0, 16'b0000_1101_1100_0010};
    tbl[8]  = '{1'b0, 16'b0000_1101_1100_0010};
    tbl[9]  = '{1'b0, 16'b0000_0010_0000_0010};
    tbl[10] = '{1'b0, 16'b0000_0010_0000_0010};
    tbl[11] = '{1'b0, 16'b0000_0000_0000_0010};
    tbl[12] = '{1'b0, 16'b0000_0000_0000_1110};
    tbl[13] = '{1'b0, 16'b0000_0000_0000_0000};

    bus.newIt_i = 1'b0;
    async_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0);

    // First iteration clears x0; second ignores newIt held through UPD and COMMIT.
    run_table(1'b1, 1'b0);
    check_int("iter_after_first", bus.iterations_o, 32'd1);
    run_table(1'b0, 1'b1);
    cycle(1'b0);
    check_int("iter_after_second", bus.iterations_o, 32'd2);

    // Abort inside DOT, then a fresh full iteration from zero.
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    async_reset();
    run_table(1'b1, 1'b0);
    check_int("iter_after_abort", bus.iterations_o, 32'd1);

    // newIt held high until saturation at MAXIT.
    async_reset();
    writes = 0;
    loads  = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1);
      if (bus.write_o) writes++;
      if (bus.load_o) loads++;
    end
    check_int("held_writes", 32'(writes), 32'(MAXIT));
    check_int("held_loads", 32'(loads), 32'(MAXIT));
    check_int("held_final", 32'(bus.final_o), 32'd1);
    check_int("held_iterations", bus.iterations_o, 32'(MAXIT));

    // Random request traffic with one asynchronous abort per round.
    for (int r = 0; r < 3; r++) begin
      async_reset();
      rc = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(0, 2) == 0);
        if (i == rc) async_reset();
      end
    end
    check_int("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
